// File: rtl/key.sv
// key: multi-channel push-button debouncer.
//
// Each raw key level passes through a 2-flop synchroniser and must then
// differ from the accepted (stable) level for DEBOUNCE_CYCLES consecutive
// clocks before it is accepted. A single sample that agrees with the
// stable level again clears the count, so short bounces never get through.
//
// Optional build macro: KEY_PULSE_EN
//   undefined : Key_Out carries the debounced level of each key.
//   defined   : Key_Out carries a one-clock pulse, registered one clock
//               after a key's debounced level rises (press event). No
//               pulse is produced on release.
//
// Channels are fully independent; Key_Out is always driven from flops.
module key #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic [N_KEYS-1:0] Key_In,
  output logic [N_KEYS-1:0] Key_Out
);

  // Counter width is derived from the debounce length.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] stable;
  logic [CNT_W-1:0]  cnt [N_KEYS];

  // Two-stage synchroniser for the asynchronous key pins.
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= Key_In;
      s2 <= s1;
    end
  end

  // Per-channel persistence counter: accept s2 once it has disagreed with
  // the stable level for DEBOUNCE_CYCLES clocks in a row. The counter
  // restarts on any agreement and after each acceptance, so it never
  // exceeds CNT_MAX and never wraps.
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      stable <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef KEY_PULSE_EN
  logic [N_KEYS-1:0] stable_d;
  logic [N_KEYS-1:0] pulse;

  // Press detector: one-clock pulse the clock after stable rises 0->1.
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      stable_d <= '0;
      pulse    <= '0;
    end else begin
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
    end
  end

  assign Key_Out = pulse;
`else
  assign Key_Out = stable;
`endif

endmodule

// File: tb/tb_key.sv
// tb_key: self-checking bench for the key debouncer (DEBOUNCE_CYCLES=16).
//
// A reference model, written as a sliding window over the sampled key
// history, predicts Key_Out for every rising edge; predictions go into
// exp_q and are compared against the DUT on the following falling edge.
// Directed latency measurements add explicit checks of the edge counts.
module tb_key;

  localparam int N = 2;
  localparam int D = 16;
`ifdef KEY_PULSE_EN
  localparam int LAT = D + 3;
`else
  localparam int LAT = D + 2;
`endif
  localparam int HIST = D + 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_out;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_q[$];
  logic         run_sb = 1'b1;

  key #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .Sys_CLK (clk),
    .Sys_RST (rst),
    .Key_In  (key_in),
    .Key_Out (key_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[j] holds the key level sampled j edges ago (hist[0] = this edge).
  // A key flips its accepted level at edge k when the samples taken at
  // edges k-D-1 .. k-2 all differ from the currently accepted level.
  logic [N-1:0] hist [HIST];
  logic [N-1:0] m_out;
  logic [N-1:0] m_out_d;

  initial begin
    logic [N-1:0] pred;
    logic         all_diff;
    for (int j = 0; j < HIST; j++) hist[j] = '0;
    m_out   = '0;
    m_out_d = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int j = 0; j < HIST; j++) hist[j] = '0;
        m_out   = '0;
        m_out_d = '0;
        pred    = '0;
      end else begin
        for (int j = HIST - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = key_in;
`ifdef KEY_PULSE_EN
        pred    = m_out & ~m_out_d;
`endif
        m_out_d = m_out;
        for (int i = 0; i < N; i++) begin
          all_diff = 1'b1;
          for (int j = 2; j <= D + 1; j++) begin
            if (hist[j][i] == m_out[i]) all_diff = 1'b0;
          end
          if (all_diff) m_out[i] = ~m_out[i];
        end
`ifndef KEY_PULSE_EN
        pred = m_out;
`endif
      end
      if (run_sb) exp_q.push_back(pred);
    end
  end

  // Scoreboard: compare each prediction half a clock after its edge.
  initial begin
    logic [N-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_out", 32'(key_out), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] v, input int cycles);
    @(negedge clk);
    key_in = v;
    repeat (cycles - 1) @(negedge clk);
  endtask

  // Called right after key_in changed on a falling edge: counts rising
  // edges (the first one samples the new level) until Key_Out[idx] is 1.
  task automatic measure(input string tag, input int idx, input int exp_lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (key_out[idx]) seen = 1'b1;
    end
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    key_in = '0;
    #1;
    check("rst_out_now", 32'(key_out), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_out_end", 32'(key_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_out", 32'(key_out), 32'd0);

    // Clean press on key 0.
    @(negedge clk);
    key_in = 2'b01;
    measure("press_lat", 0, LAT);
    check("press_k1_low", 32'(key_out[1]), 32'd0);
    repeat (20) @(negedge clk);

    // Bounce on key 1: high 10 / low 3, four times, then held high.
    for (int b = 0; b < 4; b++) begin
      drive(2'b11, 10);
      drive(2'b01, 3);
    end
    check("bounce_k1_low", 32'(key_out[1]), 32'd0);
    @(negedge clk);
    key_in = 2'b11;
    measure("bounce_lat", 1, LAT);
    repeat (20) @(negedge clk);

    // Release key 1, then swap keys on one edge.
    drive(2'b01, 30);
    @(negedge clk);
    key_in = 2'b10;
    measure("swap_lat", 1, LAT);
`ifndef KEY_PULSE_EN
    check("swap_k0_fall", 32'(key_out[0]), 32'd0);
`endif
    repeat (20) @(negedge clk);
    drive(2'b00, 30);

    // Reset in the middle of a count.
    @(negedge clk);
    key_in = 2'b11;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_now", 32'(key_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure("midrst_lat", 0, LAT);
    repeat (20) @(negedge clk);

    // Long hold then release: only one pulse (pulse mode) / stays (level).
    drive(2'b00, 100);

    // Random levels with random hold times, bounces and long holds mixed.
    for (int r = 0; r < 60; r++) begin
      drive(N'($urandom_range(0, 3)), $urandom_range(1, 25));
    end
    drive(2'b00, 40);

    run_sb = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
